// File: rtl/conv_window_gen_pkg.sv
// Shared constants, FSM state type and config decode helpers for the sliding-window generator.
package conv_window_gen_pkg;

    localparam int unsigned FeatureWidth    = 8;
    localparam int unsigned KernelSizeMax   = 5;
    localparam int unsigned DimWidthDefault = 8;

    localparam logic [2:0] Ks3     = 3'd3;
    localparam logic [2:0] Ks5     = 3'd5;
    localparam logic [1:0] Stride1 = 2'd1;
    localparam logic [1:0] Stride2 = 2'd2;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    // Anything other than an explicit 3 selects the full 5x5 kernel.
    function automatic logic [2:0] decode_ks(input logic [2:0] ks);
        return (ks == Ks3) ? Ks3 : Ks5;
    endfunction

    // Anything other than an explicit 2 selects unit stride.
    function automatic logic [1:0] decode_stride(input logic [1:0] stride);
        return (stride == Stride2) ? Stride2 : Stride1;
    endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Input row/col position tracking, stride-phase legality check and output-map coordinates.
// Counters hold the position of the next column to be accepted; outputs describe that column.
module conv_pos_counter
    import conv_window_gen_pkg::*;
#(
    parameter int unsigned DimWidth = DimWidthDefault
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                advance_i,
    input  logic [2:0]          ks_i,
    input  logic [1:0]          stride_i,
    input  logic [DimWidth-1:0] width_i,
    input  logic [DimWidth-1:0] height_i,
    output logic                win_valid_o,
    output logic [DimWidth-1:0] out_row_o,
    output logic [DimWidth-1:0] out_col_o,
    output logic                last_o
);

    logic [DimWidth-1:0] col_q, col_d;
    logic [DimWidth-1:0] row_q, row_d;
    logic [DimWidth-1:0] ks_m1;
    logic [DimWidth-1:0] col_off, row_off;
    logic                col_wrap;
    logic                stride2;

    assign ks_m1    = DimWidth'(ks_i) - DimWidth'(1);
    assign col_wrap = (col_q == width_i - DimWidth'(1));
    assign stride2  = (stride_i == Stride2);

    // Next position: column wraps at the row end and carries into the row counter.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (advance_i) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_q + DimWidth'(1);
            end else begin
                col_d = col_q + DimWidth'(1);
            end
        end
    end

    // Position register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Window legality, output coordinates and end-of-frame detect for the current column.
    always_comb begin
        col_off     = col_q - ks_m1;
        row_off     = row_q - ks_m1;
        win_valid_o = (col_q >= ks_m1) && (row_q >= ks_m1);
        if (stride2) begin
            win_valid_o = win_valid_o && !col_off[0] && !row_off[0];
            out_col_o   = col_off >> 1;
            out_row_o   = row_off >> 1;
        end else begin
            out_col_o   = col_off;
            out_row_o   = row_off;
        end
        last_o = col_wrap && (row_q == height_i - DimWidth'(1));
    end

endmodule

// File: rtl/conv_window_gen.sv
// KxK sliding-window generator: shifts line-buffer columns into a window register, maps the
// active kernel size onto the output window and flags legal conv output positions.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int unsigned DataWidth  = FeatureWidth,
    parameter int unsigned KernelSize = KernelSizeMax,
    parameter int unsigned DimWidth   = DimWidthDefault
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     start_i,
    input  logic [2:0]                               current_kernel_size_i,
    input  logic [1:0]                               stride_i,
    input  logic [DimWidth-1:0]                      fmap_width_i,
    input  logic [DimWidth-1:0]                      fmap_height_i,
    input  logic                                     col_valid_i,
    input  logic [DataWidth*KernelSize-1:0]          col_in_i,
    output logic [DataWidth*KernelSize*KernelSize-1:0] window_out_o,
    output logic                                     window_valid_o,
    output logic [DimWidth-1:0]                      out_row_o,
    output logic [DimWidth-1:0]                      out_col_o,
    output logic                                     busy_o,
    output logic                                     frame_done_o
);

    localparam int unsigned ColW  = DataWidth * KernelSize;
    localparam int unsigned WinW  = DataWidth * KernelSize * KernelSize;
    // A 3x3 kernel uses the three newest columns of the shift register.
    localparam int unsigned Off3  = KernelSize - 3;

    state_e                         state_q, state_d;
    logic [2:0]                     ks_q, ks_d;
    logic [1:0]                     stride_q, stride_d;
    logic [DimWidth-1:0]            width_q, width_d;
    logic [DimWidth-1:0]            height_q, height_d;
    logic [KernelSize-1:0][ColW-1:0] sreg_q, sreg_d;
    logic [WinW-1:0]                window_q, window_d, window_map;
    logic                           valid_q, valid_d;
    logic [DimWidth-1:0]            out_row_q, out_row_d;
    logic [DimWidth-1:0]            out_col_q, out_col_d;
    logic                           done_q, done_d;

    logic                           accept;
    logic                           pos_valid;
    logic                           pos_last;
    logic [DimWidth-1:0]            pos_row;
    logic [DimWidth-1:0]            pos_col;

    // start takes priority, so a column arriving with start is dropped.
    assign accept = col_valid_i && (state_q == StRun) && !start_i;

    conv_pos_counter #(
        .DimWidth (DimWidth)
    ) u_pos (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (start_i),
        .advance_i   (accept),
        .ks_i        (ks_q),
        .stride_i    (stride_q),
        .width_i     (width_q),
        .height_i    (height_q),
        .win_valid_o (pos_valid),
        .out_row_o   (pos_row),
        .out_col_o   (pos_col),
        .last_o      (pos_last)
    );

    // Config latch and frame FSM next state.
    always_comb begin
        state_d  = state_q;
        ks_d     = ks_q;
        stride_d = stride_q;
        width_d  = width_q;
        height_d = height_q;
        if (start_i) begin
            state_d  = StRun;
            ks_d     = decode_ks(current_kernel_size_i);
            stride_d = decode_stride(stride_i);
            width_d  = fmap_width_i;
            height_d = fmap_height_i;
        end else if (accept && pos_last) begin
            state_d = StIdle;
        end
    end

    // Column shift: oldest column at index 0, newest column enters at the top.
    always_comb begin
        sreg_d = sreg_q;
        if (accept) begin
            for (int c = 0; c < KernelSize - 1; c++) begin
                sreg_d[c] = sreg_q[c + 1];
            end
            sreg_d[KernelSize-1] = col_in_i;
        end
    end

    // Kernel-size mux from the post-shift register; unused 3x3 elements read as zero.
    always_comb begin
        window_map = '0;
        if (ks_q == Ks3) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    window_map[(r*KernelSize+c)*DataWidth +: DataWidth] =
                        sreg_d[c+Off3][r*DataWidth +: DataWidth];
                end
            end
        end else begin
            for (int r = 0; r < KernelSize; r++) begin
                for (int c = 0; c < KernelSize; c++) begin
                    window_map[(r*KernelSize+c)*DataWidth +: DataWidth] =
                        sreg_d[c][r*DataWidth +: DataWidth];
                end
            end
        end
    end

    // Output register next state: data and coordinates refresh only on accepted columns.
    always_comb begin
        window_d  = window_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        if (accept) begin
            window_d  = window_map;
            out_row_d = pos_row;
            out_col_d = pos_col;
            valid_d   = pos_valid;
            done_d    = pos_last;
        end
    end

    // State, config, shift register and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            ks_q      <= Ks5;
            stride_q  <= Stride1;
            width_q   <= '0;
            height_q  <= '0;
            sreg_q    <= '0;
            window_q  <= '0;
            valid_q   <= 1'b0;
            out_row_q <= '0;
            out_col_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ks_q      <= ks_d;
            stride_q  <= stride_d;
            width_q   <= width_d;
            height_q  <= height_d;
            sreg_q    <= sreg_d;
            window_q  <= window_d;
            valid_q   <= valid_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
            done_q    <= done_d;
        end
    end

    assign window_out_o   = window_q;
    assign window_valid_o = valid_q;
    assign out_row_o      = out_row_q;
    assign out_col_o      = out_col_q;
    assign busy_o         = (state_q == StRun);
    assign frame_done_o   = done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed testbench for conv_window_gen with a line-buffer column model and window reference.
module tb_conv_window_gen;

    localparam int DW   = 8;
    localparam int K    = 5;
    localparam int DIMW = 8;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [2:0]            ks_in;
    logic [1:0]            stride_in;
    logic [DIMW-1:0]       fmap_w;
    logic [DIMW-1:0]       fmap_h;
    logic                  col_valid;
    logic [DW*K-1:0]       col_in;
    logic [DW*K*K-1:0]     window_out;
    logic                  window_valid;
    logic [DIMW-1:0]       out_row;
    logic [DIMW-1:0]       out_col;
    logic                  busy;
    logic                  frame_done;

    int vectors;
    int miscompares;

    conv_window_gen #(
        .DataWidth  (DW),
        .KernelSize (K),
        .DimWidth   (DIMW)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .start_i               (start),
        .current_kernel_size_i (ks_in),
        .stride_i              (stride_in),
        .fmap_width_i          (fmap_w),
        .fmap_height_i         (fmap_h),
        .col_valid_i           (col_valid),
        .col_in_i              (col_in),
        .window_out_o          (window_out),
        .window_valid_o        (window_valid),
        .out_row_o             (out_row),
        .out_col_o             (out_col),
        .busy_o                (busy),
        .frame_done_o          (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pixel value of the input feature map (negative rows give don't-care filler).
    function automatic logic [7:0] pix(int y, int x);
        return 8'(y * 16 + x + 1);
    endfunction

    // Line-buffer column for input position (row,col): slice 0 is the oldest kernel row.
    function automatic logic [DW*K-1:0] make_col(int ks, int row, int col);
        logic [DW*K-1:0] v;
        for (int r = 0; r < K; r++) begin
            v[r*DW +: DW] = (r < ks) ? pix(row - ks + 1 + r, col) : 8'hA5;
        end
        return v;
    endfunction

    function automatic logic [DW*K*K-1:0] exp_win(int ks, int row, int col);
        logic [DW*K*K-1:0] v;
        v = '0;
        for (int r = 0; r < ks; r++) begin
            for (int c = 0; c < ks; c++) begin
                v[(r*K+c)*DW +: DW] = pix(row - ks + 1 + r, col - ks + 1 + c);
            end
        end
        return v;
    endfunction

    function automatic bit exp_valid(int ks, int s, int row, int col);
        return (row >= ks - 1) && (col >= ks - 1) &&
               (((row - ks + 1) % s) == 0) && (((col - ks + 1) % s) == 0);
    endfunction

    task automatic do_start(input int ks, input int s, input int w, input int h,
                            input bit with_col);
        start     = 1'b1;
        ks_in     = 3'(ks);
        stride_in = 2'(s);
        fmap_w    = DIMW'(w);
        fmap_h    = DIMW'(h);
        col_valid = with_col;
        col_in    = '1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        col_valid = 1'b0;
    endtask

    task automatic push(input logic [DW*K-1:0] col);
        col_valid = 1'b1;
        col_in    = col;
        @(posedge clk);
        #1;
        col_valid = 1'b0;
    endtask

    task automatic idle1();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) idle1();
        vectors++;
        if (window_out !== '0) begin
            miscompares++;
            $display("FAIL reset_window: got %h want 0", window_out);
        end
        vectors++;
        if ({window_valid, busy, frame_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got v%b b%b d%b want 000", window_valid, busy, frame_done);
        end
        vectors++;
        if (out_row !== '0 || out_col !== '0) begin
            miscompares++;
            $display("FAIL reset_coords: got (%0d,%0d) want (0,0)", out_row, out_col);
        end
        rst_n = 1'b1;
        idle1();
    endtask

    // Full frame, optional random idle gaps; every column checked against the reference.
    task automatic test_frame(input string name, input int ks, input int s, input int w,
                              input int h, input bit gaps, input int want_win);
        int nwin;
        bit ev;
        nwin = 0;
        do_start(ks, s, w, h, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (gaps && $urandom_range(1, 0) == 1) begin
                    idle1();
                    vectors++;
                    if (window_valid !== 1'b0 || frame_done !== 1'b0) begin
                        miscompares++;
                        $display("FAIL %s idle_quiet: got v%b d%b want 00", name,
                                 window_valid, frame_done);
                    end
                end
                push(make_col(ks, y, x));
                ev = exp_valid(ks, s, y, x);
                vectors++;
                if (window_valid !== ev) begin
                    miscompares++;
                    $display("FAIL %s valid@(%0d,%0d): got %b want %b", name, y, x,
                             window_valid, ev);
                end
                if (ev) begin
                    nwin++;
                    vectors++;
                    if (out_row !== DIMW'((y - ks + 1) / s) ||
                        out_col !== DIMW'((x - ks + 1) / s)) begin
                        miscompares++;
                        $display("FAIL %s coords@(%0d,%0d): got (%0d,%0d) want (%0d,%0d)", name,
                                 y, x, out_row, out_col, (y - ks + 1) / s, (x - ks + 1) / s);
                    end
                    vectors++;
                    if (window_out !== exp_win(ks, y, x)) begin
                        miscompares++;
                        $display("FAIL %s window@(%0d,%0d): got %h want %h", name, y, x,
                                 window_out, exp_win(ks, y, x));
                    end
                end
                vectors++;
                if (frame_done !== (y == h - 1 && x == w - 1)) begin
                    miscompares++;
                    $display("FAIL %s frame_done@(%0d,%0d): got %b", name, y, x, frame_done);
                end
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_at_end: got %b want 0", name, busy);
        end
        vectors++;
        if (nwin !== want_win) begin
            miscompares++;
            $display("FAIL %s window_count: got %0d want %0d", name, nwin, want_win);
        end
        idle1();
    endtask

    task automatic test_ks3_s1();
        test_frame("ks3_s1_6x6", 3, 1, 6, 6, 1'b0, 16);
    endtask

    task automatic test_ks5_s1();
        test_frame("ks5_s1_8x8", 5, 1, 8, 8, 1'b0, 16);
        vectors++;
        if (out_row !== 8'd3 || out_col !== 8'd3) begin
            miscompares++;
            $display("FAIL ks5_last_coords: got (%0d,%0d) want (3,3)", out_row, out_col);
        end
        vectors++;
        if (window_out[(4*K+4)*DW +: DW] !== pix(7, 7)) begin
            miscompares++;
            $display("FAIL ks5_last_elem: got %h want %h", window_out[(4*K+4)*DW +: DW],
                     pix(7, 7));
        end
    endtask

    task automatic test_ks3_s2();
        test_frame("ks3_s2_7x7", 3, 2, 7, 7, 1'b0, 9);
    endtask

    task automatic test_gaps();
        test_frame("ks3_s1_gaps", 3, 1, 6, 6, 1'b1, 16);
    endtask

    // Abort a frame with start, restart with a same-cycle column that must be dropped.
    task automatic test_restart();
        do_start(3, 1, 5, 5, 1'b0);
        for (int i = 0; i < 7; i++) begin
            push(make_col(3, i / 5, i % 5));
            vectors++;
            if (frame_done !== 1'b0) begin
                miscompares++;
                $display("FAIL restart_aborted_done: col %0d got %b want 0", i, frame_done);
            end
        end
        do_start(3, 1, 5, 5, 1'b1);
        vectors++;
        if (frame_done !== 1'b0 || window_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_pulse: got d%b v%b b%b want 0 0 1", frame_done,
                     window_valid, busy);
        end
        // Config already latched; test_frame re-pulses start with the same settings.
        test_frame("restart_5x5", 3, 1, 5, 5, 1'b0, 9);
    endtask

    task automatic test_reset_mid_frame();
        do_start(3, 1, 6, 6, 1'b0);
        for (int i = 0; i < 10; i++) push(make_col(3, i / 6, i % 6));
        rst_n     = 1'b0;
        col_valid = 1'b1;
        col_in    = make_col(3, 1, 4);
        idle1();
        col_valid = 1'b0;
        rst_n     = 1'b1;
        vectors++;
        if (window_out !== '0 || out_row !== '0 || out_col !== '0) begin
            miscompares++;
            $display("FAIL midreset_data: got win %h (%0d,%0d) want 0", window_out,
                     out_row, out_col);
        end
        vectors++;
        if ({window_valid, busy, frame_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL midreset_flags: got v%b b%b d%b want 000", window_valid, busy,
                     frame_done);
        end
        push(make_col(3, 2, 2));
        vectors++;
        if (window_valid !== 1'b0 || busy !== 1'b0 || window_out !== '0) begin
            miscompares++;
            $display("FAIL idle_col_ignored: got v%b b%b win %h want 0 0 0", window_valid,
                     busy, window_out);
        end
        test_frame("ks3_4x2_tiny", 3, 1, 4, 2, 1'b0, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        ks_in       = '0;
        stride_in   = '0;
        fmap_w      = '0;
        fmap_h      = '0;
        col_valid   = 1'b0;
        col_in      = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_ks3_s1();
        test_ks5_s1();
        test_ks3_s2();
        test_gaps();
        test_restart();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
